redirect_ctrl: RTL and testbench
================================

# redirect_ctrl

Pipeline redirect controller for the B32P CPU. Sits between the EX-stage branch/jump address logic and the fetch stage. Registers resolved jumps into a fetch redirect request, squashes wrong-path instructions, and sequences interrupt entry and return (`reti`) by arbitrating between EX jumps and pending interrupts.

## Interface
- `INT_VECTOR`, default 32'd1: word address of the interrupt service routine.
- `NUM_INT`, default 4: number of interrupt lines, 1..8.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low reset.
- `ex_valid` in 1: EX holds a valid instruction.
- `ex_pc` in 32: PC of the EX instruction.
- `jump_valid` in 1: EX jump/branch taken (includes halt).
- `jump_addr` in 32: EX jump target.
- `halt` in 1: EX instruction is `halt`.
- `reti` in 1: EX instruction is `reti`.
- `stall` in 1: pipeline frozen by memory.
- `fetch_ready` in 1: fetch accepts a redirect this cycle.
- `int_lines` in NUM_INT: asynchronous-origin interrupt inputs, already synchronized.
- `redirect_valid` out 1: redirect request to fetch.
- `redirect_addr` out 32: new fetch PC.
- `flush` out 1: squash IF/ID and ID/EX contents.
- `int_ack` out 1: one-cycle pulse on interrupt entry.
- `int_id` out 3: index of the acknowledged interrupt.
- `in_isr` out 1: ISR active.

## Operation
- FSM states: RUN, REDIR (request waiting for `fetch_ready`), ISR_RUN (RUN behaviour with `in_isr`=1), ISR_REDIR.
- Event accepted only when `ex_valid`=1 and `stall`=0. With `stall`=1, all state and outputs hold.
- Jump: `jump_valid` in RUN or ISR_RUN latches `jump_addr` into `redirect_addr` and moves to REDIR or ISR_REDIR.
- Pending interrupts: a rising edge on `int_lines[i]` sets `pend[i]`. `pend[i]` clears on acknowledge. A new edge on a line already pending is absorbed.
- Interrupt entry:
  - Allowed only in RUN, with at least one pending bit, and on an accepted EX instruction that is not a taken jump other than `halt`.
  - Lowest index wins.
  - Saves the return PC: `ex_pc`+1, or `ex_pc` when `halt`=1 so the halt re-executes after `reti`.
  - Redirects to `INT_VECTOR`, pulses `int_ack`, drives `int_id`, and moves to ISR_REDIR.
- Priority in RUN: interrupt over `halt`. A non-halt `jump_valid` wins over an interrupt. The interrupt then stays pending and is taken on the first accepted instruction after the redirect.
- `reti` in ISR_RUN redirects to the saved return PC and moves to REDIR, which leaves ISR state. `reti` outside ISR is treated as a no-op.
- Interrupts are not nested. Edges arriving during ISR are recorded in `pend`.
- REDIR/ISR_REDIR: `redirect_valid`=1 until `fetch_ready`=1. The state then returns to RUN or ISR_RUN respectively. `jump_valid` here is ignored because the EX contents are wrong-path.
- Address arithmetic is 32-bit modulo. `ex_pc`+1 at 32'hFFFFFFFF wraps to 0.

## Timing
- Redirect latency: `redirect_valid` rises on the clock edge after the accepting EX cycle (1 cycle).
- `flush` is combinational, high in the accepting cycle and for every cycle of REDIR/ISR_REDIR.
- `int_ack` is high for exactly one cycle, aligned with the first `redirect_valid` cycle of ISR_REDIR.
- Minimum redirect duration is 1 cycle, when `fetch_ready`=1 on the first request cycle.
- Reset values: state=RUN, `redirect_valid`=0, `redirect_addr`=0, `flush`=0, `int_ack`=0, `int_id`=0, `in_isr`=0, `pend`=0, return PC=0, `int_lines` history=0.
- Reset mid-redirect drops the request immediately. Pending interrupts are lost.

## Configuration
- `REDIRECT_CTRL_INT_EN` defined: full interrupt logic as above.
- Not defined:
  - Only RUN and REDIR exist.
  - `int_ack`, `in_isr` and `int_id` are tied to 0.
  - `int_lines` and `reti` are ignored.
  - No pending or return registers are synthesized.

## Structure
- Shared CPU package holds the FSM state encoding (2-bit), `INT_VECTOR` default, and `NUM_INT` max.
- One sub-module: `int_pending`. It holds edge detection, pending bits, and the lowest-index priority encoder, and outputs `any_pend` and `pend_id`. It is instantiated only under `REDIRECT_CTRL_INT_EN`.

## Test plan
- `jump_valid`=1, `jump_addr`=0x40, `fetch_ready`=1 → next cycle `redirect_valid`=1, `redirect_addr`=0x40, `flush`=1; RUN the cycle after.
- Same jump with `fetch_ready`=0 for 3 cycles → `redirect_valid` and `flush` held for 4 cycles total, address stable.
- Rising edge on `int_lines[2]` and `int_lines[1]`, EX non-jump at `ex_pc`=0x100 → `redirect_addr`=`INT_VECTOR`, `int_ack`=1, `int_id`=1, `in_isr`=1. Then `reti` → redirect 0x101, `in_isr`=0. Then line 2 taken next.
- `halt` with `ex_pc`=0x20 and pending int → ISR entry; `reti` returns to 0x20.
- `stall`=1 together with `jump_valid` for 2 cycles → no redirect until the `stall`=0 cycle, then 1-cycle latency.
- Reset low during REDIR with pending int → all outputs 0 next cycle, `pend`=0. Without `REDIRECT_CTRL_INT_EN`, the int edge produces no `int_ack`.

Source files
------------

// File: rtl/redirect_ctrl_pkg.sv
// Shared definitions for the B32P redirect controller: FSM state encoding,
// interrupt vector default, interrupt line limits and the return-PC helper.
// Optional interrupt logic is selected with REDIRECT_CTRL_INT_EN.
package redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_REDIR     = 2'd1,
    ST_ISR_RUN   = 2'd2,
    ST_ISR_REDIR = 2'd3
  } state_t;

  localparam logic [31:0] INT_VECTOR_DEF = 32'd1;
  localparam int          NUM_INT_MAX    = 8;
  localparam int          INT_ID_W       = 3;

  // A halted instruction resumes on itself so it re-executes after reti
  function automatic logic [31:0] ret_pc(input logic [31:0] pc, input logic is_halt);
    return is_halt ? pc : pc + 32'd1;
  endfunction

endpackage

// File: rtl/redirect_ctrl_if.sv
// EX/fetch side bundle of the redirect controller.
// master: pipeline side driving EX events; slave: redirect_ctrl.
interface redirect_ctrl_if
  import redirect_ctrl_pkg::*;
#(
  parameter int NUM_INT = 4
);
  logic                ex_valid;
  logic [31:0]         ex_pc;
  logic                jump_valid;
  logic [31:0]         jump_addr;
  logic                halt;
  logic                reti;
  logic                stall;
  logic                fetch_ready;
  logic [NUM_INT-1:0]  int_lines;
  logic                redirect_valid;
  logic [31:0]         redirect_addr;
  logic                flush;
  logic                int_ack;
  logic [INT_ID_W-1:0] int_id;
  logic                in_isr;

  modport master (
    output ex_valid, ex_pc, jump_valid, jump_addr, halt, reti, stall,
           fetch_ready, int_lines,
    input  redirect_valid, redirect_addr, flush, int_ack, int_id, in_isr
  );

  modport slave (
    input  ex_valid, ex_pc, jump_valid, jump_addr, halt, reti, stall,
           fetch_ready, int_lines,
    output redirect_valid, redirect_addr, flush, int_ack, int_id, in_isr
  );
endinterface

// File: rtl/redirect_ctrl_int_pending.sv
// Interrupt pending tracker: rising-edge detect per line, sticky pending
// bits cleared on acknowledge, lowest-index priority encoder.
// Only exists when REDIRECT_CTRL_INT_EN is defined.
`ifdef REDIRECT_CTRL_INT_EN
module redirect_ctrl_int_pending
  import redirect_ctrl_pkg::*;
#(
  parameter int NUM_INT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_INT-1:0]  i_lines,
  input  logic                i_ack,
  input  logic [INT_ID_W-1:0] i_ack_id,
  output logic                o_any_pend,
  output logic [INT_ID_W-1:0] o_pend_id
);
  logic [NUM_INT-1:0] r_lines_d;
  logic [NUM_INT-1:0] r_pend;
  logic [NUM_INT-1:0] w_rise;
  logic [NUM_INT-1:0] w_ack_mask;

  assign w_rise     = i_lines & ~r_lines_d;
  assign o_any_pend = |r_pend;

  // Decode the acknowledged line into a clear mask
  always_comb begin
    w_ack_mask = '0;
    for (int i = 0; i < NUM_INT; i++) begin
      w_ack_mask[i] = i_ack && (i_ack_id == INT_ID_W'(i));
    end
  end

  // Edge history and sticky pending bits; edges on pending lines merge
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_lines_d <= '0;
      r_pend    <= '0;
    end else begin
      r_lines_d <= i_lines;
      r_pend    <= (r_pend & ~w_ack_mask) | w_rise;
    end
  end

  // Scan downward so the smallest pending index is the one left standing
  always_comb begin
    o_pend_id = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (r_pend[i]) o_pend_id = INT_ID_W'(i);
    end
  end
endmodule
`endif

// File: rtl/redirect_ctrl.sv
// Pipeline redirect controller: turns accepted EX jumps into a held fetch
// redirect, squashes wrong-path work, and sequences interrupt entry/reti.
// Define REDIRECT_CTRL_INT_EN for the interrupt logic; otherwise only
// RUN/REDIR exist and the interrupt outputs are tied low.
module redirect_ctrl
  import redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] INT_VECTOR = INT_VECTOR_DEF,
  parameter int          NUM_INT    = 4
) (
  input logic            clk,
  input logic            reset,
  redirect_ctrl_if.slave bus
);
  state_t      r_state, w_state_nxt;
  logic [31:0] r_redirect_addr, w_redirect_addr_nxt;
  logic        w_accept;
  logic        w_take_now;
  logic        w_redirect_valid;

  assign w_accept = bus.ex_valid & ~bus.stall;

`ifdef REDIRECT_CTRL_INT_EN
  logic [31:0]         r_ret_pc, w_ret_pc_nxt;
  logic                r_int_ack, w_int_take;
  logic [INT_ID_W-1:0] r_int_id;
  logic                w_any_pend, w_int_entry;
  logic [INT_ID_W-1:0] w_pend_id;

  redirect_ctrl_int_pending #(.NUM_INT(NUM_INT)) u_int_pending (
    .clk        (clk),
    .reset      (reset),
    .i_lines    (bus.int_lines),
    .i_ack      (w_int_take),
    .i_ack_id   (w_pend_id),
    .o_any_pend (w_any_pend),
    .o_pend_id  (w_pend_id)
  );

  // halt loses to an interrupt; any other taken jump beats it
  assign w_int_entry = w_any_pend & (~bus.jump_valid | bus.halt);
`endif

  // Next state, redirect target and interrupt entry decode
  always_comb begin
    w_state_nxt         = r_state;
    w_redirect_addr_nxt = r_redirect_addr;
    w_take_now          = 1'b0;
`ifdef REDIRECT_CTRL_INT_EN
    w_int_take          = 1'b0;
    w_ret_pc_nxt        = r_ret_pc;
`endif
    case (r_state)
      ST_RUN: begin
        if (w_accept) begin
`ifdef REDIRECT_CTRL_INT_EN
          if (w_int_entry) begin
            w_int_take          = 1'b1;
            w_take_now          = 1'b1;
            w_ret_pc_nxt        = ret_pc(bus.ex_pc, bus.halt);
            w_redirect_addr_nxt = INT_VECTOR;
            w_state_nxt         = ST_ISR_REDIR;
          end else
`endif
          if (bus.jump_valid) begin
            w_take_now          = 1'b1;
            w_redirect_addr_nxt = bus.jump_addr;
            w_state_nxt         = ST_REDIR;
          end
        end
      end
      ST_REDIR: begin
        if (!bus.stall && bus.fetch_ready) w_state_nxt = ST_RUN;
      end
`ifdef REDIRECT_CTRL_INT_EN
      ST_ISR_RUN: begin
        if (w_accept) begin
          if (bus.reti) begin
            w_take_now          = 1'b1;
            w_redirect_addr_nxt = r_ret_pc;
            w_state_nxt         = ST_REDIR;
          end else if (bus.jump_valid) begin
            w_take_now          = 1'b1;
            w_redirect_addr_nxt = bus.jump_addr;
            w_state_nxt         = ST_ISR_REDIR;
          end
        end
      end
      ST_ISR_REDIR: begin
        if (!bus.stall && bus.fetch_ready) w_state_nxt = ST_ISR_RUN;
      end
`endif
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // State, target and interrupt bookkeeping registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= ST_RUN;
      r_redirect_addr <= '0;
`ifdef REDIRECT_CTRL_INT_EN
      r_ret_pc        <= '0;
      r_int_ack       <= 1'b0;
      r_int_id        <= '0;
`endif
    end else begin
      r_state         <= w_state_nxt;
      r_redirect_addr <= w_redirect_addr_nxt;
`ifdef REDIRECT_CTRL_INT_EN
      r_ret_pc        <= w_ret_pc_nxt;
      r_int_ack       <= w_int_take;
      if (w_int_take) r_int_id <= w_pend_id;
`endif
    end
  end

  assign w_redirect_valid   = (r_state == ST_REDIR) || (r_state == ST_ISR_REDIR);
  assign bus.redirect_valid = w_redirect_valid;
  assign bus.redirect_addr  = r_redirect_addr;
  assign bus.flush          = w_take_now | w_redirect_valid;

`ifdef REDIRECT_CTRL_INT_EN
  assign bus.int_ack = r_int_ack;
  assign bus.int_id  = r_int_id;
  assign bus.in_isr  = (r_state == ST_ISR_RUN) || (r_state == ST_ISR_REDIR);
`else
  assign bus.int_ack = 1'b0;
  assign bus.int_id  = '0;
  assign bus.in_isr  = 1'b0;

  logic w_unused_int;
  assign w_unused_int = ^{bus.int_lines, bus.reti, bus.halt, bus.ex_pc, INT_VECTOR, NUM_INT};
`endif
endmodule

// File: tb/tb_redirect_ctrl.sv
// Scoreboard bench for redirect_ctrl: each accepted redirect pushes its
// expected target/ack/id/isr; a monitor pops on every new redirect request.
module tb_redirect_ctrl;
  import redirect_ctrl_pkg::*;

  localparam logic [31:0] VEC = 32'h0000_0010;
  localparam int          NI  = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic        ack;
    logic [2:0]  id;
    logic        isr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  redirect_ctrl_if #(.NUM_INT(NI)) bus ();

  redirect_ctrl #(.INT_VECTOR(VEC), .NUM_INT(NI)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t sb_q[$];
  exp_t mon_e;
  logic rv_prev = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Pop one expectation per rising redirect request
  always @(negedge clk) begin
    if (bus.redirect_valid && !rv_prev) begin
      if (sb_q.size() == 0) begin
        check_val("sb_unexpected_redirect", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("sb_addr", bus.redirect_addr, mon_e.addr);
        check_val("sb_int_ack", bus.int_ack, mon_e.ack);
        check_val("sb_in_isr", bus.in_isr, mon_e.isr);
        if (mon_e.ack) check_val("sb_int_id", bus.int_id, mon_e.id);
      end
    end
    rv_prev = bus.redirect_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ex_valid    = 1'b0;
    bus.ex_pc       = '0;
    bus.jump_valid  = 1'b0;
    bus.jump_addr   = '0;
    bus.halt        = 1'b0;
    bus.reti        = 1'b0;
    bus.stall       = 1'b0;
    bus.fetch_ready = 1'b1;
  endtask

  task automatic drive_ex(input logic [31:0] pc, input logic jv, input logic [31:0] ja,
                          input logic hl, input logic rt);
    bus.ex_valid   = 1'b1;
    bus.ex_pc      = pc;
    bus.jump_valid = jv;
    bus.jump_addr  = ja;
    bus.halt       = hl;
    bus.reti       = rt;
  endtask

  // EX already driven: expect accept now, one request cycle, then idle
  task automatic accept_redirect(input logic [31:0] a, input logic ack, input logic [2:0] id,
                                 input logic isr);
    sb_q.push_back({a, ack, id, isr});
    #1 check_val("flush_accept", bus.flush, 1);
    tick();
    idle();
    #1;
    check_val("rv_request", bus.redirect_valid, 1);
    check_val("flush_request", bus.flush, 1);
    check_val("isr_request", bus.in_isr, isr);
    tick();
    check_val("rv_done", bus.redirect_valid, 0);
    check_val("flush_done", bus.flush, 0);
    check_val("ack_done", bus.int_ack, 0);
  endtask

  initial begin
    bus.int_lines = '0;
    idle();
    reset = 1'b0;
    repeat (3) tick();
    check_val("rst_rv", bus.redirect_valid, 0);
    check_val("rst_addr", bus.redirect_addr, 0);
    check_val("rst_flush", bus.flush, 0);
    check_val("rst_ack", bus.int_ack, 0);
    check_val("rst_id", bus.int_id, 0);
    check_val("rst_isr", bus.in_isr, 0);
    reset = 1'b1;
    tick();

    // Plain jump, fetch ready immediately
    drive_ex(32'h10, 1'b1, 32'h40, 1'b0, 1'b0);
    accept_redirect(32'h40, 1'b0, 3'd0, 1'b0);

    // Fetch back-pressure for 3 cycles; wrong-path jumps in REDIR ignored
    drive_ex(32'h30, 1'b1, 32'h80, 1'b0, 1'b0);
    bus.fetch_ready = 1'b0;
    sb_q.push_back({32'h80, 1'b0, 3'd0, 1'b0});
    #1 check_val("bp_flush_accept", bus.flush, 1);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive_ex(32'h31 + 32'(k), 1'b1, 32'hDEAD, 1'b0, 1'b0);
      bus.fetch_ready = (k == 3);
      #1;
      check_val("bp_rv_hold", bus.redirect_valid, 1);
      check_val("bp_flush_hold", bus.flush, 1);
      check_val("bp_addr_hold", bus.redirect_addr, 32'h80);
      tick();
    end
    idle();
    #1;
    check_val("bp_rv_after", bus.redirect_valid, 0);
    check_val("bp_flush_after", bus.flush, 0);

    // Stall blocks acceptance, then freezes the pending request
    drive_ex(32'h50, 1'b1, 32'h200, 1'b0, 1'b0);
    bus.stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1 check_val("stall_flush", bus.flush, 0);
      tick();
      check_val("stall_rv", bus.redirect_valid, 0);
    end
    bus.stall = 1'b0;
    sb_q.push_back({32'h200, 1'b0, 3'd0, 1'b0});
    #1 check_val("stall_flush_accept", bus.flush, 1);
    tick();
    idle();
    check_val("stall_rv_request", bus.redirect_valid, 1);
    bus.stall = 1'b1;
    tick();
    check_val("stall_rv_frozen", bus.redirect_valid, 1);
    check_val("stall_addr_frozen", bus.redirect_addr, 32'h200);
    bus.stall = 1'b0;
    tick();
    check_val("stall_rv_release", bus.redirect_valid, 0);

`ifdef REDIRECT_CTRL_INT_EN
    // Two lines pending: line 1 first, line 2 recorded and taken after reti
    bus.int_lines = 4'b0110;
    tick();
    drive_ex(32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    accept_redirect(VEC, 1'b1, 3'd1, 1'b1);
    check_val("isr_run", bus.in_isr, 1);
    drive_ex(32'h150, 1'b0, 32'h0, 1'b0, 1'b1);
    accept_redirect(32'h101, 1'b0, 3'd0, 1'b0);
    drive_ex(32'h300, 1'b0, 32'h0, 1'b0, 1'b0);
    accept_redirect(VEC, 1'b1, 3'd2, 1'b1);
    drive_ex(32'h350, 1'b0, 32'h0, 1'b0, 1'b1);
    accept_redirect(32'h301, 1'b0, 3'd0, 1'b0);

    // Non-halt jump beats a pending interrupt, which follows right after
    bus.int_lines = 4'b0000;
    tick();
    bus.int_lines = 4'b0001;
    tick();
    drive_ex(32'h480, 1'b1, 32'h500, 1'b0, 1'b0);
    accept_redirect(32'h500, 1'b0, 3'd0, 1'b0);
    drive_ex(32'h600, 1'b0, 32'h0, 1'b0, 1'b0);
    accept_redirect(VEC, 1'b1, 3'd0, 1'b1);
    drive_ex(32'h650, 1'b0, 32'h0, 1'b0, 1'b1);
    accept_redirect(32'h601, 1'b0, 3'd0, 1'b0);

    // Return PC wraps past the top of the address space
    bus.int_lines = 4'b0000;
    tick();
    bus.int_lines = 4'b0001;
    tick();
    drive_ex(32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 1'b0);
    accept_redirect(VEC, 1'b1, 3'd0, 1'b1);
    drive_ex(32'h700, 1'b0, 32'h0, 1'b0, 1'b1);
    accept_redirect(32'h0, 1'b0, 3'd0, 1'b0);

    // Interrupt wins over halt; reti re-executes the halt
    bus.int_lines = 4'b0000;
    tick();
    bus.int_lines = 4'b1000;
    tick();
    drive_ex(32'h20, 1'b1, 32'h20, 1'b1, 1'b0);
    accept_redirect(VEC, 1'b1, 3'd3, 1'b1);
    drive_ex(32'h40, 1'b0, 32'h0, 1'b0, 1'b1);
    accept_redirect(32'h20, 1'b0, 3'd0, 1'b0);
`endif

    // Reset in the middle of a redirect with an interrupt pending
    bus.int_lines = 4'b0000;
    tick();
    bus.int_lines = 4'b0010;
    tick();
    drive_ex(32'h680, 1'b1, 32'h700, 1'b0, 1'b0);
    bus.fetch_ready = 1'b0;
    sb_q.push_back({32'h700, 1'b0, 3'd0, 1'b0});
    tick();
    idle();
    bus.fetch_ready = 1'b0;
    check_val("rstmid_rv_before", bus.redirect_valid, 1);
    reset = 1'b0;
    bus.int_lines = 4'b0000;
    tick();
    check_val("rstmid_rv", bus.redirect_valid, 0);
    check_val("rstmid_addr", bus.redirect_addr, 0);
    check_val("rstmid_flush", bus.flush, 0);
    check_val("rstmid_ack", bus.int_ack, 0);
    check_val("rstmid_id", bus.int_id, 0);
    check_val("rstmid_isr", bus.in_isr, 0);
    reset = 1'b1;
    bus.fetch_ready = 1'b1;
    tick();
    // Lost pending interrupt and a reti outside ISR: nothing happens
    drive_ex(32'h800, 1'b0, 32'h0, 1'b0, 1'b1);
    #1 check_val("post_rst_flush", bus.flush, 0);
    tick();
    idle();
    check_val("post_rst_rv", bus.redirect_valid, 0);
    check_val("post_rst_ack", bus.int_ack, 0);

`ifndef REDIRECT_CTRL_INT_EN
    // Interrupt edges have no effect without the interrupt logic
    bus.int_lines = 4'b0001;
    tick();
    drive_ex(32'h900, 1'b0, 32'h0, 1'b0, 1'b0);
    #1 check_val("noint_flush", bus.flush, 0);
    tick();
    idle();
    check_val("noint_rv", bus.redirect_valid, 0);
    check_val("noint_ack", bus.int_ack, 0);
    check_val("noint_isr", bus.in_isr, 0);
`endif

    tick();
    check_val("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
